// File: rtl/magnitude_scheduler_pkg.sv
// Shared widths, requester ids and packed tag/result types for the magnitude scheduler.
package magnitude_scheduler_pkg;

    localparam int DW      = 12;
    localparam int MW      = DW + 1;
    localparam logic ID_A  = 1'b0;
    localparam logic ID_B  = 1'b1;
    localparam int TAG_W   = 2;
    localparam int ENTRY_W = MW + 1;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    typedef struct packed {
        logic          id;
        logic [MW-1:0] mag;
    } res_entry_t;

endpackage

// File: rtl/magnitude_scheduler_fifo.sv
// Synchronous first-word-fall-through result FIFO; head visible the edge after push.
// Pushes while full are dropped unless a pop happens on the same edge.
module mag_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 14
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop, full;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/magnitude_scheduler.sv
// Round-robin sharing of a fixed-latency magnitude datapath between requesters A and B.
// Results return in issue order via FWFT FIFO; credits stop grants so the FIFO never overflows.
module magnitude_scheduler
    import magnitude_scheduler_pkg::*;
#(
    parameter int MAG_LATENCY = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          a_valid_i,
    input  logic [DW-1:0] a_x_i,
    input  logic [DW-1:0] a_y_i,
    output logic          a_ready_o,
    input  logic          b_valid_i,
    input  logic [DW-1:0] b_x_i,
    input  logic [DW-1:0] b_y_i,
    output logic          b_ready_o,
    output logic [DW-1:0] mag_x_o,
    output logic [DW-1:0] mag_y_o,
    input  logic [MW-1:0] mag_magnitude_i,
    output logic          res_valid_o,
    output logic          res_id_o,
    output logic [MW-1:0] res_mag_o,
    input  logic          res_ready_i,
    output logic          busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(FIFO_DEPTH + MAG_LATENCY) + 1;

    tag_t          tag_q [MAG_LATENCY];
    tag_t          tag_d;
    logic [DW-1:0] mag_x_q, mag_x_d;
    logic [DW-1:0] mag_y_q, mag_y_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_a, grant_b;
    logic [SW-1:0] inflight_count;
    logic [SW-1:0] credit_used;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_pop, credit_ok;
    res_entry_t    push_entry, head_entry;

    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < MAG_LATENCY; i++) begin
            inflight_count = inflight_count + SW'(tag_q[i].vld);
        end
    end

    // Every issued sample owns a FIFO slot from issue until it is popped.
    assign credit_used = inflight_count + SW'(fifo_count);
    assign credit_ok   = (credit_used < SW'(FIFO_DEPTH));

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (credit_ok) begin
            if (a_valid_i && b_valid_i) begin
                if (last_grant_q == ID_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (a_valid_i) begin
                grant_a = 1'b1;
            end else if (b_valid_i) begin
                grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        mag_x_d      = '0;
        mag_y_d      = '0;
        tag_d.vld    = 1'b0;
        tag_d.id     = ID_A;
        last_grant_d = last_grant_q;
        if (grant_a) begin
            mag_x_d      = a_x_i;
            mag_y_d      = a_y_i;
            tag_d.vld    = 1'b1;
            tag_d.id     = ID_A;
            last_grant_d = ID_A;
        end else if (grant_b) begin
            mag_x_d      = b_x_i;
            mag_y_d      = b_y_i;
            tag_d.vld    = 1'b1;
            tag_d.id     = ID_B;
            last_grant_d = ID_B;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mag_x_q      <= '0;
            mag_y_q      <= '0;
            last_grant_q <= ID_B;
            for (int i = 0; i < MAG_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            mag_x_q      <= mag_x_d;
            mag_y_q      <= mag_y_d;
            last_grant_q <= last_grant_d;
            tag_q[0]     <= tag_d;
            for (int i = 1; i < MAG_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // The tag leaving the pipe lines up with the datapath result for the same sample.
    assign push_entry.id  = tag_q[MAG_LATENCY-1].id;
    assign push_entry.mag = mag_magnitude_i;
    assign fifo_pop       = !fifo_empty && res_ready_i;

    mag_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_result_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .push_i     (tag_q[MAG_LATENCY-1].vld),
        .push_dat_i (push_entry),
        .pop_i      (fifo_pop),
        .head_dat_o (head_entry),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign a_ready_o   = grant_a;
    assign b_ready_o   = grant_b;
    assign mag_x_o     = mag_x_q;
    assign mag_y_o     = mag_y_q;
    assign res_valid_o = !fifo_empty;
    assign res_id_o    = head_entry.id;
    assign res_mag_o   = head_entry.mag;
    assign busy_o      = (inflight_count != '0) || !fifo_empty;

endmodule
